// File: rtl/rr_slot_arbiter.sv
// rr_slot_arbiter
//   Round-robin arbiter that grants one shared resource to one of NUM_REQ
//   requesters at a time. A wrapping priority pointer decides who wins when
//   the resource is idle. A hold counter limits each grant to MAX_HOLD cycles.
//   Only the granted requester may drive the shared datapath.
//
// Ports
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high reset
//   req      : per-requester request level (bit i = requester i)
//   grant    : registered one-hot grant, or all-zero
//   grant_id : index of the current owner, valid only while busy is high
//   busy     : high while a grant is active
//   timeout  : one-cycle pulse in the first idle cycle after a forced release
//
// States
//   S_IDLE  | no owner; arbitrate from ptr and grant on the next edge
//   S_GRANT | owner grant_id holds the resource and hold_cnt counts cycles
module rr_slot_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_HOLD = 4,
  parameter int ID_W     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);
  // One extra bit so that NUM_REQ == 2**ID_W does not wrap to zero.
  localparam logic [ID_W:0]     NUM_REQ_X = (ID_W + 1)'(NUM_REQ);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;

  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W:0]       cand;
  logic                rel_vol;
  logic                rel_forced;
  logic [ID_W-1:0]     ptr_after_owner;

  // Scan ptr, ptr+1, ... modulo NUM_REQ; the first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W + 1)'(k);
      if (cand >= NUM_REQ_X) begin
        cand = cand - NUM_REQ_X;
      end
      if (!win_found && req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  assign rel_vol         = !req[id_q];
  assign rel_forced      = (hold_q == HOLD_LAST);
  assign ptr_after_owner = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    id_d      = id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d         = S_GRANT;
          grant_d         = '0;
          grant_d[win_id] = 1'b1;
          id_d            = win_id;
          busy_d          = 1'b1;
          hold_d          = '0;
        end
      end
      S_GRANT: begin
        if (rel_vol || rel_forced) begin
          state_d   = S_IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          hold_d    = '0;
          ptr_d     = ptr_after_owner;
          // A requester that lets go on its last allowed cycle was not cut off.
          timeout_d = rel_forced && !rel_vol;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      id_q      <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

  // Embedded properties; the first cycle after reset is excluded so that
  // history-based checks never look back into the reset period.
  logic past_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      past_valid_q <= 1'b0;
    end else begin
      past_valid_q <= 1'b1;
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (reset || !past_valid_q)
    $onehot0(grant_q));

  a_busy_matches: assert property (@(posedge clk) disable iff (reset || !past_valid_q)
    busy_q == (|grant_q));

  a_ptr_range: assert property (@(posedge clk) disable iff (reset || !past_valid_q)
    {1'b0, ptr_q} < NUM_REQ_X);

  a_hold_range: assert property (@(posedge clk) disable iff (reset || !past_valid_q)
    hold_q <= HOLD_LAST);

  a_timeout_idle: assert property (@(posedge clk) disable iff (reset || !past_valid_q)
    timeout_q |-> (grant_q == '0));

  a_hold_limit: assert property (@(posedge clk) disable iff (reset || !past_valid_q)
    (busy_q && (hold_q == HOLD_LAST)) |=> !busy_q);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rise_chk
    a_grant_needs_req: assert property (@(posedge clk) disable iff (reset || !past_valid_q)
      $rose(grant_q[gi]) |-> $past(req[gi]));
  end

endmodule

// File: tb/tb_rr_slot_arbiter.sv
module tb_rr_slot_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [2:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  rr_slot_arbiter #(
    .NUM_REQ (3),
    .MAX_HOLD(4),
    .ID_W    (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .grant   (grant),
    .grant_id(grant_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 3'b000;
    repeat (2) tick();
    n_tests++;
    if ({grant, grant_id, busy, timeout} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b id=%0d busy=%b timeout=%b, need all zero",
               grant, grant_id, busy, timeout);
    end
    n_tests++;
    if (dut.ptr_q !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_ptr: got %0d, need 0", dut.ptr_q);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if (grant !== 3'b000 || busy !== 1'b0 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_req c=%0d: got grant=%b busy=%b timeout=%b, need 000/0/0",
                 c, grant, busy, timeout);
      end
    end
  endtask

  // req=111 from ptr=0: owners 0,1,2 each for 4 cycles, one idle cycle with a
  // timeout pulse after each, period 15.
  task automatic test_rotation();
    logic [2:0] exp_g;
    logic       exp_t;
    int         p;
    req = 3'b111;
    for (int c = 0; c < 30; c++) begin
      tick();
      p = c % 15;
      if ((p % 5) == 4) begin
        exp_g = 3'b000;
        exp_t = 1'b1;
      end else begin
        exp_g = 3'b001 << (p / 5);
        exp_t = 1'b0;
      end
      n_tests++;
      if (grant !== exp_g || timeout !== exp_t || busy !== (exp_g != 3'b000)) begin
        n_fail++;
        $display("FAIL rotation c=%0d: got grant=%b timeout=%b busy=%b, need grant=%b timeout=%b",
                 c, grant, timeout, busy, exp_g, exp_t);
      end
      if (exp_g != 3'b000) begin
        n_tests++;
        if (grant_id !== 2'(p / 5)) begin
          n_fail++;
          $display("FAIL rotation_id c=%0d: got %0d, need %0d", c, grant_id, p / 5);
        end
      end
    end
    req = 3'b000;
    tick();
    n_tests++;
    if (grant !== 3'b000 || timeout !== 1'b0 || dut.ptr_q !== 2'd0) begin
      n_fail++;
      $display("FAIL rotation_end: got grant=%b timeout=%b ptr=%0d, need 000/0/0",
               grant, timeout, dut.ptr_q);
    end
  endtask

  task automatic test_single();
    req = 3'b010;
    tick();
    n_tests++;
    if (grant !== 3'b010 || grant_id !== 2'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_first: got grant=%b id=%0d busy=%b, need 010/1/1", grant, grant_id, busy);
    end
    tick();
    n_tests++;
    if (grant !== 3'b010) begin
      n_fail++;
      $display("FAIL single_second: got grant=%b, need 010", grant);
    end
    req = 3'b000;
    tick();
    n_tests++;
    if (grant !== 3'b000 || busy !== 1'b0 || timeout !== 1'b0 || dut.ptr_q !== 2'd2) begin
      n_fail++;
      $display("FAIL single_release: got grant=%b busy=%b timeout=%b ptr=%0d, need 000/0/0/2",
               grant, busy, timeout, dut.ptr_q);
    end
  endtask

  // Owner 2 releases voluntarily; ptr wraps to 0, then 0 and 1 follow.
  task automatic test_wrap();
    req = 3'b100;
    tick();
    n_tests++;
    if (grant !== 3'b100 || grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL wrap_owner2: got grant=%b id=%0d, need 100/2", grant, grant_id);
    end
    req = 3'b011;
    tick();
    n_tests++;
    if (grant !== 3'b000 || timeout !== 1'b0 || dut.ptr_q !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_release: got grant=%b timeout=%b ptr=%0d, need 000/0/0",
               grant, timeout, dut.ptr_q);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (grant !== 3'b001 || grant_id !== 2'd0) begin
        n_fail++;
        $display("FAIL wrap_owner0 c=%0d: got grant=%b id=%0d, need 001/0", c, grant, grant_id);
      end
    end
    tick();
    n_tests++;
    if (grant !== 3'b000 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_forced: got grant=%b timeout=%b, need 000/1", grant, timeout);
    end
    tick();
    n_tests++;
    if (grant !== 3'b010 || grant_id !== 2'd1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_owner1: got grant=%b id=%0d timeout=%b, need 010/1/0",
               grant, grant_id, timeout);
    end
    req = 3'b000;
    tick();
    n_tests++;
    if (grant !== 3'b000 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_done: got grant=%b timeout=%b, need 000/0", grant, timeout);
    end
  endtask

  // req[0] falls on the last allowed cycle: release without timeout, ptr=1.
  task automatic test_coincide();
    req = 3'b001;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (grant !== 3'b001) begin
        n_fail++;
        $display("FAIL coincide_hold c=%0d: got grant=%b, need 001", c, grant);
      end
    end
    req = 3'b000;
    tick();
    n_tests++;
    if (grant !== 3'b000 || timeout !== 1'b0 || dut.ptr_q !== 2'd1) begin
      n_fail++;
      $display("FAIL coincide_release: got grant=%b timeout=%b ptr=%0d, need 000/0/1",
               grant, timeout, dut.ptr_q);
    end
    req = 3'b011;
    tick();
    n_tests++;
    if (grant !== 3'b010 || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL coincide_next: got grant=%b id=%0d, need 010/1", grant, grant_id);
    end
    req = 3'b000;
    tick();
    n_tests++;
    if (grant !== 3'b000) begin
      n_fail++;
      $display("FAIL coincide_done: got grant=%b, need 000", grant);
    end
  endtask

  task automatic test_async_reset();
    req = 3'b100;
    tick();
    n_tests++;
    if (grant !== 3'b100) begin
      n_fail++;
      $display("FAIL areset_pre: got grant=%b, need 100", grant);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (grant !== 3'b000 || busy !== 1'b0 || dut.ptr_q !== 2'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: got grant=%b busy=%b ptr=%0d, need 000/0/0",
               grant, busy, dut.ptr_q);
    end
    req = 3'b101;
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_tests++;
    if (grant !== 3'b001 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL areset_first: got grant=%b id=%0d, need 001/0", grant, grant_id);
    end
    req = 3'b000;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req   = 3'b000;
    test_reset();
    test_rotation();
    test_single();
    test_wrap();
    test_coincide();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
